// File: rtl/mem_pkg.sv
// Shared types and constants for the synchronous data memory controller.
// Holds the controller state encoding, the default top-word preset and the lane-count helper.
package mem_pkg;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } mem_state_t;

  localparam logic [15:0] TOP_INIT_DEFAULT = 16'h00FF;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word storage with per-byte-lane synchronous write and a registered read port.
// No reset on the array or read register so the storage can map onto block RAM.
module sram_array
  import mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                       clk,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic [lanes(DATA_W)-1:0]   we_i,
  input  logic                       re_i,
  output logic [DATA_W-1:0]          rdata_o
);

  localparam int LANES = lanes(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) begin
      if (we_i[k]) begin
        mem_q[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
      end
    end
    // Read port only moves on a read so the last read value is held.
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_mem_ctrl.sv
// Clocked data memory controller: req/ready handshake, byte-lane writes, one-cycle reads,
// and a clear sequencer that zeroes every word after reset and presets the top word.
module sync_mem_ctrl
  import mem_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [DATA_W-1:0] TOP_INIT = DATA_W'(TOP_INIT_DEFAULT),
  parameter bit                DO_CLEAR = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         writeData,
  input  logic [lanes(DATA_W)-1:0]  wbe,
  output logic                      ready,
  output logic [DATA_W-1:0]         data,
  output logic                      rvalid,
  output logic                      busy
);

  localparam int                LANES     = lanes(DATA_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  if ((DATA_W % 8 != 0) || (ADDR_W < 1)) begin : g_param_check
    $error("sync_mem_ctrl: DATA_W must be a multiple of 8 and ADDR_W >= 1");
  end

  mem_state_t        state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic              ready_q;
  logic              busy_q;
  logic              rvalid_q;
  logic              dvalid_q;

  logic              accept;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [LANES-1:0]  mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign accept = req & ready_q;
  assign cnt_d  = cnt_q + ADDR_W'(1);

  // The clear sequencer owns the write port until the last word is written.
  always_comb begin
    mem_addr  = address;
    mem_wdata = writeData;
    mem_we    = '0;
    mem_re    = 1'b0;
    if (state_q == S_CLEAR) begin
      mem_addr  = cnt_q;
      mem_wdata = (cnt_q == LAST_ADDR) ? TOP_INIT : '0;
      mem_we    = '1;
    end else if (accept) begin
      if (we) begin
        mem_we = wbe;
      end else begin
        mem_re = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DO_CLEAR ? S_CLEAR : S_READY;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      busy_q   <= DO_CLEAR;
      rvalid_q <= 1'b0;
      dvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST_ADDR) begin
            state_q <= S_READY;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_READY: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept && !we) begin
            rvalid_q <= 1'b1;
            dvalid_q <= 1'b1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  sram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .addr_i  (mem_addr),
    .wdata_i (mem_wdata),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .rdata_o (mem_rdata)
  );

  // The array's read register has no reset; mask it until a read has landed since reset.
  assign data   = dvalid_q ? mem_rdata : '0;
  assign ready  = ready_q;
  assign rvalid = rvalid_q;
  assign busy   = busy_q;

endmodule
